// File: rtl/keypad_operand_loader.sv
// keypad_operand_loader: scans a 4x4 hex keypad and debounces full scan frames.
// Accepted hex digits build operand A and then operand B, eight digits each, MSB nibble first.
// The finished operand pair is offered to the floating-point adder on a valid/ready handshake.
module keypad_operand_loader #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_line,
  output logic [3:0]  row_line,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        entry_sel,
  output logic [3:0]  digit_cnt,
  output logic        key_strobe,
  output logic [3:0]  key_code
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, ISSUE} state_t;

  // Frame result: 0 = NONE, 1 = SINGLE, 2 = MULTI (more than one bit seen).
  typedef logic [1:0] seen_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   slot_cnt;
  seen_t           acc_cnt, merged_cnt;
  logic [3:0]      acc_code, merged_code;
  logic [3:0]      cand, cand_nxt;
  logic [3:0]      stable_cnt, stable_nxt;
  logic [3:0]      none_cnt, none_nxt;
  logic            armed, armed_nxt;
  logic            accept;

  logic            slot_end, frame_end;
  logic [1:0]      row_idx, col_idx;
  logic [2:0]      col_bits, seen_sum;

  logic [31:0]     op_a_nxt, op_b_nxt;
  logic            op_valid_nxt, entry_sel_nxt;
  logic [3:0]      digit_cnt_nxt;
  logic            last_digit;

  assign slot_end  = (slot_cnt == SW'(SCAN_DIV - 1));
  assign frame_end = slot_end && row_line[3];

  // Decode the driven row and the sensed column, and count the sensed bits in this slot.
  always_comb begin
    row_idx = 2'd0;
    unique case (row_line)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    col_idx = 2'd0;
    if (col_line[0])      col_idx = 2'd0;
    else if (col_line[1]) col_idx = 2'd1;
    else if (col_line[2]) col_idx = 2'd2;
    else if (col_line[3]) col_idx = 2'd3;
    col_bits = {2'b00, col_line[0]} + {2'b00, col_line[1]}
             + {2'b00, col_line[2]} + {2'b00, col_line[3]};
  end

  // Merge this slot's sample into the frame accumulator (count saturates at MULTI).
  always_comb begin
    seen_sum    = {1'b0, acc_cnt} + col_bits;
    merged_cnt  = (seen_sum >= 3'd2) ? seen_t'(2) : seen_sum[1:0];
    merged_code = (acc_cnt == 2'd0) ? {col_idx, row_idx} : acc_code;
  end

  // Debounce decision at frame end: candidate tracking, re-arm on a NONE run, single accept.
  always_comb begin
    cand_nxt   = cand;
    stable_nxt = stable_cnt;
    none_nxt   = none_cnt;
    armed_nxt  = armed;
    accept     = 1'b0;
    if (frame_end) begin
      unique case (merged_cnt)
        2'd0: begin
          stable_nxt = 4'd0;
          none_nxt   = (none_cnt == 4'hF) ? none_cnt : none_cnt + 4'd1;
          if (none_nxt >= DEB) armed_nxt = 1'b1;
        end
        2'd1: begin
          none_nxt = 4'd0;
          if (merged_code == cand) begin
            stable_nxt = (stable_cnt == 4'hF) ? stable_cnt : stable_cnt + 4'd1;
          end else begin
            cand_nxt   = merged_code;
            stable_nxt = 4'd1;
          end
        end
        default: begin
          stable_nxt = 4'd0;
          none_nxt   = 4'd0;
        end
      endcase
      if (armed && stable_nxt >= DEB) begin
        accept    = 1'b1;
        armed_nxt = 1'b0;
      end
    end
  end

  // Scan and debounce registers; these run continuously in every entry state.
  // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt   <= '0;
      row_line   <= 4'b0001;
      acc_cnt    <= 2'd0;
      acc_code   <= 4'd0;
      cand       <= 4'd0;
      stable_cnt <= 4'd0;
      none_cnt   <= 4'd0;
      armed      <= 1'b1;
      key_strobe <= 1'b0;
      key_code   <= 4'd0;
    end else begin
      key_strobe <= accept;
      if (accept) key_code <= cand_nxt;
      cand       <= cand_nxt;
      stable_cnt <= stable_nxt;
      none_cnt   <= none_nxt;
      armed      <= armed_nxt;
      if (slot_end) begin
        slot_cnt <= '0;
        row_line <= {row_line[2:0], row_line[3]};
        if (frame_end) begin
          acc_cnt  <= 2'd0;
          acc_code <= 4'd0;
        end else begin
          acc_cnt  <= merged_cnt;
          acc_code <= merged_code;
        end
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

  // Entry FSM next state and datapath next values; every output gets a default first.
  // NOTE: the defaults hold every value, so no path through this block can infer a latch.
  always_comb begin
    state_nxt     = state;
    op_a_nxt      = op_a;
    op_b_nxt      = op_b;
    op_valid_nxt  = op_valid;
    entry_sel_nxt = entry_sel;
    digit_cnt_nxt = digit_cnt;
    last_digit    = (digit_cnt == 4'd7);
    unique case (state)
      ENTER_A: begin
        if (accept) begin
          op_a_nxt = (digit_cnt == 4'd0) ? {28'h0, cand_nxt} : {op_a[27:0], cand_nxt};
          if (last_digit) begin
            digit_cnt_nxt = 4'd0;
            entry_sel_nxt = 1'b1;
            state_nxt     = ENTER_B;
          end else begin
            digit_cnt_nxt = digit_cnt + 4'd1;
          end
        end
      end
      ENTER_B: begin
        if (accept) begin
          op_b_nxt = (digit_cnt == 4'd0) ? {28'h0, cand_nxt} : {op_b[27:0], cand_nxt};
          if (last_digit) begin
            digit_cnt_nxt = 4'd0;
            op_valid_nxt  = 1'b1;
            state_nxt     = ISSUE;
          end else begin
            digit_cnt_nxt = digit_cnt + 4'd1;
          end
        end
      end
      ISSUE: begin
        if (op_valid && op_ready) begin
          op_valid_nxt  = 1'b0;
          entry_sel_nxt = 1'b0;
          state_nxt     = ENTER_A;
        end
      end
      default: state_nxt = ENTER_A;
    endcase
  end

  // Entry FSM state and operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ENTER_A;
      op_a      <= 32'h0;
      op_b      <= 32'h0;
      op_valid  <= 1'b0;
      entry_sel <= 1'b0;
      digit_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      op_valid  <= op_valid_nxt;
      entry_sel <= entry_sel_nxt;
      digit_cnt <= digit_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_operand_loader.sv
// Directed bench for keypad_operand_loader with SCAN_DIV=2 and DEBOUNCE_SCANS=2 (8-cycle frames).
module tb_keypad_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_line;
  logic [3:0]  row_line;
  logic [31:0] op_a, op_b;
  logic        op_valid, op_ready, entry_sel, key_strobe;
  logic [3:0]  digit_cnt, key_code;

  logic [15:0] keys;          // bit c set = key with code c is held
  int          checks = 0;
  int          failures = 0;
  int          strobe_cnt = 0;
  logic        valid_at [0:255];
  int          base;
  logic [3:0]  exp_row;
  logic [3:0]  digs [16];

  always #5 clk = ~clk;

  keypad_operand_loader #(.SCAN_DIV(2), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst(rst), .col_line(col_line), .row_line(row_line),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .entry_sel(entry_sel), .digit_cnt(digit_cnt),
    .key_strobe(key_strobe), .key_code(key_code)
  );

  // Keypad matrix: key code 4*k+s connects row s to column k.
  always_comb begin
    col_line = 4'b0000;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++)
        if (row_line[s] && keys[4*k+s]) col_line[k] = 1'b1;
  end

  // Count strobes and record op_valid in the same cycle as each strobe.
  always @(posedge clk) begin
    if (key_strobe) begin
      if (strobe_cnt < 256) valid_at[strobe_cnt] <= op_valid;
      strobe_cnt <= strobe_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold one key for 4 frames, then release for 4 frames (enough to accept and re-arm).
  task automatic press(input logic [3:0] code);
    keys = 16'h0001 << code;
    repeat (32) @(negedge clk);
    keys = 16'h0000;
    repeat (32) @(negedge clk);
  endtask

  // Align to the first negedge of a frame (row 0 just driven).
  task automatic sync_frame();
    for (int i = 0; i < 20 && row_line != 4'b1000; i++) @(negedge clk);
    for (int i = 0; i < 20 && row_line != 4'b0001; i++) @(negedge clk);
    check("frame_sync", {28'h0, row_line}, 32'h1);
  endtask

  initial begin
    digs = '{4'h4, 4'h0, 4'h4, 4'h9, 4'h0, 4'hF, 4'hD, 4'hB,
             4'h3, 4'hF, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    rst = 1'b1; keys = 16'h0; op_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Test 1: asynchronous reset mid-slot, then row rotation every 2 cycles.
    #2 rst = 1'b1;
    #1;
    check("rst_row",        {28'h0, row_line},   32'h1);
    check("rst_op_a",       op_a,                32'h0);
    check("rst_op_b",       op_b,                32'h0);
    check("rst_op_valid",   {31'h0, op_valid},   32'h0);
    check("rst_entry_sel",  {31'h0, entry_sel},  32'h0);
    check("rst_digit_cnt",  {28'h0, digit_cnt},  32'h0);
    check("rst_key_strobe", {31'h0, key_strobe}, 32'h0);
    check("rst_key_code",   {28'h0, key_code},   32'h0);
    @(negedge clk) rst = 1'b0;
    exp_row = 4'b0001;
    check("rot_0", {28'h0, row_line}, {28'h0, exp_row});
    for (int i = 1; i <= 4; i++) begin
      repeat (2) @(negedge clk);
      exp_row = {exp_row[2:0], exp_row[3]};
      check($sformatf("rot_%0d", i), {28'h0, row_line}, {28'h0, exp_row});
    end

    // Test 2: key B (col 2, row 3) for 3 frames, released -> one accept.
    sync_frame();
    base = strobe_cnt;
    keys = 16'h0800;
    repeat (24) @(negedge clk);
    keys = 16'h0;
    repeat (32) @(negedge clk);
    check("kb_strobes",   strobe_cnt - base,  32'd1);
    check("kb_key_code",  {28'h0, key_code},  32'hB);
    check("kb_op_a",      op_a,               32'h0000000B);
    check("kb_digit_cnt", {28'h0, digit_cnt}, 32'd1);

    // Test 3: alternating SINGLE/NONE frames, then MULTI frames -> no accept.
    sync_frame();
    base = strobe_cnt;
    for (int i = 0; i < 4; i++) begin
      keys = 16'h0800;
      repeat (8) @(negedge clk);
      keys = 16'h0;
      repeat (8) @(negedge clk);
    end
    check("alt_no_strobe", strobe_cnt - base, 32'd0);
    base = strobe_cnt;
    keys = 16'h0003;
    repeat (32) @(negedge clk);
    keys = 16'h0;
    repeat (32) @(negedge clk);
    check("multi_no_strobe", strobe_cnt - base, 32'd0);
    check("multi_op_a",      op_a,              32'h0000000B);

    // Test 4: full operand entry from a fresh reset.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    base = strobe_cnt;
    for (int i = 0; i < 8; i++) begin
      press(digs[i]);
      if (i == 6) begin
        check("a7_entry_sel", {31'h0, entry_sel}, 32'h0);
        check("a7_digit_cnt", {28'h0, digit_cnt}, 32'd7);
      end
    end
    check("a_op_a",      op_a,               32'h40490FDB);
    check("a_entry_sel", {31'h0, entry_sel}, 32'h1);
    check("a_digit_cnt", {28'h0, digit_cnt}, 32'd0);
    check("a_op_valid",  {31'h0, op_valid},  32'h0);
    for (int i = 8; i < 16; i++) press(digs[i]);
    check("b_op_b",        op_b,                       32'h3F800000);
    check("b_op_a",        op_a,                       32'h40490FDB);
    check("b_op_valid",    {31'h0, op_valid},          32'h1);
    check("b_digit_cnt",   {28'h0, digit_cnt},         32'd0);
    check("b_strobes",     strobe_cnt - base,          32'd16);
    check("valid_at_15th", {31'h0, valid_at[base+14]}, 32'h0);
    check("valid_at_16th", {31'h0, valid_at[base+15]}, 32'h1);

    // Test 5: ISSUE holds operands, keys strobe but are discarded, then handshake.
    repeat (50) @(negedge clk);
    check("iss_hold_valid", {31'h0, op_valid}, 32'h1);
    base = strobe_cnt;
    press(4'h7);
    check("iss_strobes",   strobe_cnt - base,   32'd1);
    check("iss_key_code",  {28'h0, key_code},   32'h7);
    check("iss_digit_cnt", {28'h0, digit_cnt},  32'd0);
    check("iss_op_valid",  {31'h0, op_valid},   32'h1);
    check("iss_op_a",      op_a,                32'h40490FDB);
    check("iss_op_b",      op_b,                32'h3F800000);
    op_ready = 1'b1;
    @(negedge clk) op_ready = 1'b0;
    check("hs_op_valid",  {31'h0, op_valid},  32'h0);
    check("hs_entry_sel", {31'h0, entry_sel}, 32'h0);
    check("hs_op_a",      op_a,               32'h40490FDB);
    press(4'h5);
    check("newa_op_a",      op_a,               32'h00000005);
    check("newa_digit_cnt", {28'h0, digit_cnt}, 32'd1);

    // Test 6: reset after 5 digits of B; a key held across reset is accepted once into A.
    for (int i = 1; i < 8; i++) press(4'(i));
    check("r_op_a",      op_a,               32'h51234567);
    check("r_entry_sel", {31'h0, entry_sel}, 32'h1);
    press(4'h8); press(4'h9); press(4'hA); press(4'hC); press(4'hE);
    check("r_op_b",      op_b,               32'h00089ACE);
    check("r_digit_cnt", {28'h0, digit_cnt}, 32'd5);
    keys = 16'h0040;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("r_rst_op_a",      op_a,               32'h0);
    check("r_rst_op_b",      op_b,               32'h0);
    check("r_rst_entry_sel", {31'h0, entry_sel}, 32'h0);
    check("r_rst_digit_cnt", {28'h0, digit_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = strobe_cnt;
    repeat (32) @(negedge clk);
    keys = 16'h0;
    repeat (32) @(negedge clk);
    check("held_strobes",   strobe_cnt - base,   32'd1);
    check("held_key_code",  {28'h0, key_code},   32'h6);
    check("held_op_a",      op_a,                32'h00000006);
    check("held_digit_cnt", {28'h0, digit_cnt},  32'd1);
    check("held_entry_sel", {31'h0, entry_sel},  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
